// File: rtl/lsq_issue.sv
// lsq_issue: load/store queue issue stage.
// Buffers dispatched load/store operations in program order in a circular
// buffer and presents the head entry to the data cache through a
// ready/accept handshake. In-flight cache requests are capped at MAX_OUT by
// counting issues against completion pulses.
//
// Ports:
//   clk, reset (async, active-low)
//   dispatch_valid/opcode/address/data/tag -> enqueue request, dispatch_ready back
//   flush           squash all queued, not-yet-issued entries
//   ls_ready/opcode/address/data/tag        -> head entry offered to the cache
//   cache_ready     cache accepts the head entry this cycle
//   cache_done      one-cycle completion pulse
//   count           occupied entries
//   outstanding     issued-but-not-completed requests
//   err             sticky: completion seen with nothing outstanding
module lsq_issue #(
  parameter int DEPTH   = 8,
  parameter int MAX_OUT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dispatch_valid,
  input  logic                    dispatch_opcode,
  input  logic [31:0]             dispatch_address,
  input  logic [31:0]             dispatch_data,
  input  logic [5:0]              dispatch_tag,
  output logic                    dispatch_ready,
  input  logic                    flush,
  output logic                    ls_ready,
  output logic                    ls_opcode,
  output logic [31:0]             ls_address,
  output logic [31:0]             ls_data,
  output logic [5:0]              ls_tag,
  input  logic                    cache_ready,
  input  logic                    cache_done,
  output logic [$clog2(DEPTH):0]  count,
  output logic [3:0]              outstanding,
  output logic                    err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic        mem_op   [DEPTH];
  logic [31:0] mem_addr [DEPTH];
  logic [31:0] mem_data [DEPTH];
  logic [5:0]  mem_tag  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          issue;

  // No push-through-pop: a full queue refuses dispatch even on an issue cycle.
  assign dispatch_ready = (count < CW'(DEPTH));
  assign ls_ready       = (count != '0) && (outstanding < 4'(MAX_OUT)) && !flush;
  assign push           = dispatch_valid && dispatch_ready && !flush;
  assign issue          = ls_ready && cache_ready;

  assign ls_opcode  = mem_op[rd_ptr];
  assign ls_address = mem_addr[rd_ptr];
  assign ls_data    = mem_data[rd_ptr];
  assign ls_tag     = mem_tag[rd_ptr];

  // Storage is cleared on reset so the payload outputs read zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_op[i]   <= 1'b0;
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
        mem_tag[i]  <= '0;
      end
    end else if (push) begin
      mem_op[wr_ptr]   <= dispatch_opcode;
      mem_addr[wr_ptr] <= dispatch_address;
      mem_data[wr_ptr] <= dispatch_data;
      mem_tag[wr_ptr]  <= dispatch_tag;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Flush does not touch outstanding: requests already issued still complete.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (issue && !cache_done)
        outstanding <= outstanding + 4'd1;
      else if (!issue && cache_done && (outstanding != '0))
        outstanding <= outstanding - 4'd1;
      if (cache_done && (outstanding == '0))
        err <= 1'b1;
    end
  end

endmodule
